reorder_buffer_param: RTL and testbench

//  Parametrised circular reorder buffer for the out-of-order mips_core.
//  - Allocates one entry per dispatched instruction, in program order.
//  - Captures results from the common data bus (CDB).
//  - Retires one ready head entry per cycle to the register-rename/commit stage.
//  - Supports selective squash (younger than a branch tag) and full flush.
//  - Generalises the fixed 2-entry ROB to any power-of-two depth and adds occupancy reporting.

---
 rtl/reorder_buffer_param.sv | 123 ++++++++++++
 tb/tb_reorder_buffer_param.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/reorder_buffer_param.sv
// reorder_buffer_param: circular reorder buffer with in-order alloc/commit, CDB capture, squash and flush
// Ports:
//   clk, rst_n                       clock and asynchronous active-low reset
//   alloc_valid/ready, alloc_*       dispatch side; alloc_tag is the tail index handed out
//   wb_valid, wb_tag, wb_value       common data bus writeback into a valid entry
//   commit_ready/valid, commit_*     head entry presented for retirement
//   squash_valid, squash_tag         drop entries younger than squash_tag (the tag itself survives)
//   flush_all                        drop every entry
//   count                            occupied entries, 0..DEPTH
module reorder_buffer_param #(
  parameter int DEPTH      = 4,
  parameter int DEPTH_BITS = 2,
  parameter int DATA_WIDTH = 32,
  parameter int PREG_BITS  = 6
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  alloc_valid,
  output logic                  alloc_ready,
  input  logic [1:0]            alloc_inst_type,
  input  logic [PREG_BITS-1:0]  alloc_reg_dest,
  input  logic [4:0]            alloc_logic_dest,
  output logic [DEPTH_BITS-1:0] alloc_tag,
  input  logic                  wb_valid,
  input  logic [DEPTH_BITS-1:0] wb_tag,
  input  logic [DATA_WIDTH-1:0] wb_value,
  input  logic                  commit_ready,
  output logic                  commit_valid,
  output logic [DEPTH_BITS-1:0] commit_tag,
  output logic [1:0]            commit_inst_type,
  output logic [PREG_BITS-1:0]  commit_reg_dest,
  output logic [4:0]            commit_logic_dest,
  output logic [DATA_WIDTH-1:0] commit_value,
  input  logic                  squash_valid,
  input  logic [DEPTH_BITS-1:0] squash_tag,
  input  logic                  flush_all,
  output logic [DEPTH_BITS:0]   count
);
  localparam int PW = DEPTH_BITS + 1;
  logic [PW-1:0]         head_q, head_d, tail_q, tail_d;
  logic [DEPTH-1:0]      valid_q, valid_d, ready_q, ready_d;
  logic [1:0]            type_q [DEPTH];
  logic [1:0]            type_d [DEPTH];
  logic [PREG_BITS-1:0]  rdest_q [DEPTH];
  logic [PREG_BITS-1:0]  rdest_d [DEPTH];
  logic [4:0]            ldest_q [DEPTH];
  logic [4:0]            ldest_d [DEPTH];
  logic [DATA_WIDTH-1:0] value_q [DEPTH];
  logic [DATA_WIDTH-1:0] value_d [DEPTH];
  logic [DEPTH_BITS-1:0] head_idx, tail_idx, sq_off;
  logic                  do_alloc, do_commit;
  assign head_idx          = head_q[DEPTH_BITS-1:0];
  assign tail_idx          = tail_q[DEPTH_BITS-1:0];
  assign count             = tail_q - head_q;
  assign alloc_ready       = (count != PW'(DEPTH)) && !squash_valid && !flush_all;
  assign alloc_tag         = tail_idx;
  assign commit_valid      = valid_q[head_idx] && ready_q[head_idx];
  assign commit_tag        = head_idx;
  assign commit_inst_type  = type_q[head_idx];
  assign commit_reg_dest   = rdest_q[head_idx];
  assign commit_logic_dest = ldest_q[head_idx];
  assign commit_value      = value_q[head_idx];
  assign do_alloc          = alloc_valid && alloc_ready;
  assign do_commit         = commit_valid && commit_ready && !flush_all;
  // age of the squashing branch relative to head; everything older than it is kept
  assign sq_off            = squash_tag - head_idx;
  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    valid_d = valid_q;
    ready_d = ready_q;
    type_d  = type_q;
    rdest_d = rdest_q;
    ldest_d = ldest_q;
    value_d = value_q;
    if (wb_valid && valid_q[wb_tag]) begin
      ready_d[wb_tag] = 1'b1;
      value_d[wb_tag] = wb_value;
    end
    if (do_commit) begin
      valid_d[head_idx] = 1'b0;
      head_d = head_q + PW'(1);
    end
    if (do_alloc) begin
      valid_d[tail_idx] = 1'b1;
      ready_d[tail_idx] = 1'b0;
      type_d[tail_idx]  = alloc_inst_type;
      rdest_d[tail_idx] = alloc_reg_dest;
      ldest_d[tail_idx] = alloc_logic_dest;
      tail_d = tail_q + PW'(1);
    end
    if (flush_all) begin
      valid_d = '0;
      tail_d  = head_q;
    end else if (squash_valid) begin
      // rebuilding tail from head keeps the wrap bit consistent with age order
      tail_d = head_q + {1'b0, sq_off} + PW'(1);
      for (int i = 0; i < DEPTH; i++)
        if (DEPTH_BITS'(DEPTH_BITS'(i) - head_idx) > sq_off) valid_d[i] = 1'b0;
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head_q  <= '0;
      tail_q  <= '0;
      valid_q <= '0;
      ready_q <= '0;
      type_q  <= '{default: '0};
      rdest_q <= '{default: '0};
      ldest_q <= '{default: '0};
      value_q <= '{default: '0};
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      valid_q <= valid_d;
      ready_q <= ready_d;
      type_q  <= type_d;
      rdest_q <= rdest_d;
      ldest_q <= ldest_d;
      value_q <= value_d;
    end
  end
endmodule

// File: tb/tb_reorder_buffer_param.sv
// tb_reorder_buffer_param: directed and random checks of the ROB against an in-order queue model
module tb_reorder_buffer_param;
  localparam int D = 4;
  logic        clk = 0, rst_n = 0;
  logic        alloc_valid, alloc_ready;
  logic [1:0]  alloc_inst_type;
  logic [5:0]  alloc_reg_dest;
  logic [4:0]  alloc_logic_dest;
  logic [1:0]  alloc_tag;
  logic        wb_valid;
  logic [1:0]  wb_tag;
  logic [31:0] wb_value;
  logic        commit_ready, commit_valid;
  logic [1:0]  commit_tag, commit_inst_type;
  logic [5:0]  commit_reg_dest;
  logic [4:0]  commit_logic_dest;
  logic [31:0] commit_value;
  logic        squash_valid;
  logic [1:0]  squash_tag;
  logic        flush_all;
  logic [2:0]  count;
  int checks = 0, errors = 0;
  reorder_buffer_param dut (
    .clk(clk), .rst_n(rst_n),
    .alloc_valid(alloc_valid), .alloc_ready(alloc_ready), .alloc_inst_type(alloc_inst_type),
    .alloc_reg_dest(alloc_reg_dest), .alloc_logic_dest(alloc_logic_dest), .alloc_tag(alloc_tag),
    .wb_valid(wb_valid), .wb_tag(wb_tag), .wb_value(wb_value),
    .commit_ready(commit_ready), .commit_valid(commit_valid), .commit_tag(commit_tag),
    .commit_inst_type(commit_inst_type), .commit_reg_dest(commit_reg_dest),
    .commit_logic_dest(commit_logic_dest), .commit_value(commit_value),
    .squash_valid(squash_valid), .squash_tag(squash_tag), .flush_all(flush_all), .count(count)
  );
  always #5 clk = ~clk;
  typedef struct {
    logic [1:0]  it;
    logic [5:0]  rd;
    logic [4:0]  ld;
    bit          rdy;
    logic [31:0] val;
  } ent_t;
  ent_t mq[$];
  int   mhead = 0;
  int   sz, keep;
  bit   cv, ar;
  task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0h want %0h at %0t", nm, act, exp, $time);
    end
  endtask
  // model: live instructions in age order; head tag advances one per retirement
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mq.delete();
      mhead = 0;
    end else begin
      sz = mq.size();
      cv = sz > 0 && mq[0].rdy;
      ar = sz < D && !squash_valid && !flush_all;
      if (flush_all) mq.delete();
      else begin
        if (wb_valid)
          for (int i = 0; i < sz; i++)
            if ((mhead + i) % D == int'(wb_tag)) begin
              mq[i].rdy = 1;
              mq[i].val = wb_value;
            end
        if (squash_valid) begin
          keep = (int'(squash_tag) - mhead + D) % D + 1;
          while (mq.size() > keep) void'(mq.pop_back());
        end
        if (cv && commit_ready) begin
          void'(mq.pop_front());
          mhead = (mhead + 1) % D;
        end
        if (alloc_valid && ar)
          mq.push_back('{alloc_inst_type, alloc_reg_dest, alloc_logic_dest, 1'b0, 32'h0});
      end
    end
  end
  always @(negedge clk) begin
    if (rst_n) begin
      chk("m_count", count, mq.size());
      chk("m_alloc_ready", alloc_ready, mq.size() < D && !squash_valid && !flush_all);
      chk("m_alloc_tag", alloc_tag, (mhead + mq.size()) % D);
      chk("m_commit_valid", commit_valid, mq.size() > 0 && mq[0].rdy);
      if (mq.size() > 0 && mq[0].rdy) begin
        chk("m_commit_tag", commit_tag, mhead);
        chk("m_commit_type", commit_inst_type, mq[0].it);
        chk("m_commit_rd", commit_reg_dest, mq[0].rd);
        chk("m_commit_ld", commit_logic_dest, mq[0].ld);
        chk("m_commit_value", commit_value, mq[0].val);
      end
    end
  end
  task automatic idle();
    alloc_valid = 0; alloc_inst_type = 0; alloc_reg_dest = 0; alloc_logic_dest = 0;
    wb_valid = 0; wb_tag = 0; wb_value = 0; commit_ready = 0;
    squash_valid = 0; squash_tag = 0; flush_all = 0;
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic do_reset();
    idle();
    rst_n = 0;
    tick();
    rst_n = 1;
  endtask
  task automatic rand_fields();
    alloc_inst_type  = 2'($urandom);
    alloc_reg_dest   = 6'($urandom);
    alloc_logic_dest = 5'($urandom);
  endtask
  task automatic alloc_n(int n);
    for (int i = 0; i < n; i++) begin
      alloc_valid = 1;
      rand_fields();
      tick();
    end
    alloc_valid = 0;
  endtask
  initial begin
    idle();
    #2;
    chk("rst_count", count, 0);
    chk("rst_commit_valid", commit_valid, 0);
    chk("rst_commit_value", commit_value, 0);
    chk("rst_alloc_tag", alloc_tag, 0);
    @(posedge clk);
    #1 rst_n = 1;
    #1 chk("rst_alloc_ready", alloc_ready, 1);
    // four allocations fill the buffer
    for (int i = 0; i < 4; i++) begin
      alloc_valid = 1;
      rand_fields();
      #1 chk("t1_alloc_tag", alloc_tag, i);
      tick();
    end
    alloc_valid = 0;
    #1;
    chk("t1_count", count, 4);
    chk("t1_alloc_ready", alloc_ready, 0);
    chk("t1_commit_valid", commit_valid, 0);
    // out-of-order writeback, in-order retirement
    wb_valid = 1; wb_tag = 1; wb_value = 32'h55;
    tick();
    wb_tag = 0; wb_value = 32'hAA;
    #1 chk("t2_cv_same_cycle", commit_valid, 0);
    tick();
    wb_valid = 0; commit_ready = 1;
    #1;
    chk("t2_cv_next", commit_valid, 1);
    chk("t2_val0", commit_value, 32'hAA);
    tick();
    #1 chk("t2_val1", commit_value, 32'h55);
    tick();
    commit_ready = 0;
    #1 chk("t2_count", count, 2);
    // tags wrap around the ring
    do_reset();
    commit_ready = 1;
    for (int k = 0; k < 6; k++) begin
      alloc_valid = 1;
      rand_fields();
      wb_valid = k > 0; wb_tag = 2'((k + 3) % 4); wb_value = k - 1;
      #1;
      chk("t3_alloc_tag", alloc_tag, k % 4);
      chk("t3_count_le4", count <= 4, 1);
      tick();
    end
    alloc_valid = 0; wb_valid = 1; wb_tag = 1; wb_value = 5;
    tick();
    wb_valid = 0;
    tick();
    tick();
    #1 chk("t3_drained", count, 0);
    // squash keeps the branch and everything older
    do_reset();
    alloc_n(4);
    squash_valid = 1; squash_tag = 1;
    tick();
    squash_valid = 0;
    #1;
    chk("t4_count", count, 2);
    chk("t4_alloc_tag", alloc_tag, 2);
    wb_valid = 1; wb_tag = 3; wb_value = 32'h33;
    tick();
    wb_tag = 0; wb_value = 32'h10;
    tick();
    wb_tag = 1; wb_value = 32'h11; commit_ready = 1;
    tick();
    wb_valid = 0;
    tick();
    tick();
    #1;
    chk("t4_count_end", count, 0);
    chk("t4_cv_end", commit_valid, 0);
    commit_ready = 0;
    // flush drops a ready head
    do_reset();
    alloc_n(3);
    for (int i = 0; i < 3; i++) begin
      wb_valid = 1; wb_tag = 2'(i); wb_value = 32'h100 + i;
      tick();
    end
    wb_valid = 0; flush_all = 1; commit_ready = 1;
    #1 chk("t5_cv_before", commit_valid, 1);
    tick();
    flush_all = 0; commit_ready = 0;
    #1;
    chk("t5_count", count, 0);
    chk("t5_cv", commit_valid, 0);
    chk("t5_alloc_tag", alloc_tag, 0);
    // asynchronous reset mid-commit
    do_reset();
    alloc_n(2);
    wb_valid = 1; wb_tag = 0; wb_value = 32'h77;
    tick();
    wb_valid = 0; commit_ready = 1;
    #1 chk("t6_cv_before", commit_valid, 1);
    #2 rst_n = 0;
    #1;
    chk("t6_count", count, 0);
    chk("t6_cv", commit_valid, 0);
    idle();
    tick();
    rst_n = 1;
    // random traffic against the model
    for (int c = 0; c < 3000; c++) begin
      idle();
      alloc_valid = $urandom_range(0, 9) < 7;
      rand_fields();
      wb_valid = $urandom_range(0, 1) == 1;
      wb_tag = 2'($urandom);
      wb_value = $urandom;
      commit_ready = $urandom_range(0, 9) < 6;
      if (mq.size() > 0 && $urandom_range(0, 19) == 0) begin
        squash_valid = 1;
        squash_tag = 2'((mhead + $urandom_range(0, mq.size() - 1)) % D);
      end
      flush_all = $urandom_range(0, 49) == 0;
      tick();
    end
    idle();
    tick();
    tick();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
